// File: rtl/fetch_queue_pkg.sv
// Shared fetch front-end constants and the queued {pc, inst} entry type.
// Used by fetch_queue and fetch_fifo.
package fetch_queue_pkg;

  localparam int INST_WIDTH = 32;
  localparam int PC_WIDTH   = 32;

  localparam logic [PC_WIDTH-1:0] FETCH_STRIDE   = 32'd4;
  localparam logic [PC_WIDTH-1:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
    return {pc[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, inst} entries with flush.
// The head reads as zero whenever the buffer is empty.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  push_entry,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != CW'(DEPTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observable through count.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency
// word reads, and queues {pc, inst} pairs for decode with redirect/halt.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                  DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [PC_WIDTH-3:0]     imem_addr,
  input  logic [INST_WIDTH-1:0]   imem_data,
  input  logic                    halt,
  input  logic                    redirect,
  input  logic [PC_WIDTH-1:0]     redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INST_WIDTH-1:0]   out_inst,
  output logic [PC_WIDTH-1:0]     out_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] inflight_pc;
  logic                inflight;
  logic                squash;
  logic                issue;
  logic                push;
  logic                pop;
  logic [CW-1:0]       count;
  logic [CW:0]         occupancy;
  fetch_entry_t        head;
  fetch_entry_t        push_entry;

  // Reserve a slot for the outstanding read so a return can never overflow.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight);
  assign issue     = !reset && !halt && !redirect && (occupancy < (CW+1)'(DEPTH));
  assign pc_next   = fetch_pc + FETCH_STRIDE;

  assign imem_req  = issue;
  assign imem_addr = issue ? fetch_pc[PC_WIDTH-1:2] : '0;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !redirect;
  assign push      = inflight && !squash && !redirect;

  assign push_entry.pc   = inflight_pc;
  assign push_entry.inst = imem_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= align_pc(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
      squash      <= 1'b0;
    end else begin
      squash <= redirect;
      if (redirect) begin
        fetch_pc <= align_pc(redirect_pc);
        inflight <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          inflight_pc <= fetch_pc;
          fetch_pc    <= pc_next;
        end
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head       (head),
    .count      (count)
  );

  assign out_inst = head.inst;
  assign out_pc   = head.pc;

endmodule
